// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer stage feeding the 1011 sequence detector.
package seq_serializer_pkg;

    // Default word width when the instantiating level does not override it.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Legal word width range.
    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    // Shifter state codes; the detector uses the same encoding for its own FSM.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Counter width needed to index WIDTH bits (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bus of the serializer: valid/ready word handshake plus serial output.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             sequence_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;

    // Word producer side.
    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  sequence_out,
        input  bit_valid,
        input  word_done,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output sequence_out,
        output bit_valid,
        output word_done,
        output busy
    );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage: one-word holding register in front of a shifter that
// streams words gaplessly, one bit per clock, toward the 1011 detector.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    seq_serializer_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Reject out-of-range widths at elaboration.
    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_check
        $error("seq_serializer: WIDTH must be within 2..32");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             word_ready_q, word_ready_d;
    logic             sequence_out_q, sequence_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;

    logic             accept_c;
    logic             last_bit_c;
    logic             load_c;

    // Handshake completes only while the holding register is empty.
    assign accept_c   = bus.word_valid && !hold_full_q;
    // Shifter is presenting the final bit of the current word.
    assign last_bit_c = (state_q == S_SHIFT) && (bit_cnt_q == LAST_CNT);
    // Hold-to-shift transfer: from idle, or back-to-back at the last bit.
    assign load_c     = hold_full_q && ((state_q == S_IDLE) || last_bit_c);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave idle once a word is held; return only when no word follows.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = hold_full_q ? S_SHIFT : S_IDLE;
            S_SHIFT: state_d = (last_bit_c && !hold_full_q) ? S_IDLE : S_SHIFT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: hold capture, shifter load/shift, bit counter.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;

        if (accept_c) begin
            hold_d      = bus.word_in;
            hold_full_d = 1'b1;
        end

        if (load_c) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
        end else if (state_q == S_SHIFT) begin
            shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            // The counter saturates at the last bit; it only wraps on reload.
            if (!last_bit_c) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output next values, derived from next state so every output is a flop.
    always_comb begin
        word_ready_d   = !hold_full_d;
        bit_valid_d    = (state_d == S_SHIFT);
        sequence_out_d = bit_valid_d && (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]);
        word_done_d    = bit_valid_d && (bit_cnt_d == LAST_CNT);
        busy_d         = bit_valid_d || hold_full_d;
    end

    // Datapath and output registers; reset discards any word in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            word_ready_q   <= 1'b1;
            sequence_out_q <= 1'b0;
            bit_valid_q    <= 1'b0;
            word_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            word_ready_q   <= word_ready_d;
            sequence_out_q <= sequence_out_d;
            bit_valid_q    <= bit_valid_d;
            word_done_q    <= word_done_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.word_ready   = word_ready_q;
    assign bus.sequence_out = sequence_out_q;
    assign bus.bit_valid    = bit_valid_q;
    assign bus.word_done    = word_done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance driven with the
// same words, checked every cycle against a timeline model of accepted words.
module tb_seq_serializer;

    localparam int W = 8;

    logic clk;
    logic rst;

    seq_serializer_if #(.WIDTH(W)) if_m ();
    seq_serializer_if #(.WIDTH(W)) if_l ();

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock (clk),
        .reset (rst),
        .bus   (if_m)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock (clk),
        .reset (rst),
        .bus   (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each accepted word has an accept edge and a first-bit edge.
    logic [7:0] wq[$];
    int         aq[$];
    int         sq[$];
    int         last_s;
    int         n;
    int         compared;
    int         mismatched;
    logic [7:0] cap_m;
    logic [7:0] cap_l;

    // Expected outputs just after edge e, from the accepted-word timeline.
    function automatic void model(input int e, output logic hf, output logic bv,
                                  output logic bm, output logic bl, output logic wd);
        hf = 1'b0; bv = 1'b0; bm = 1'b0; bl = 1'b0; wd = 1'b0;
        foreach (wq[i]) begin
            logic [7:0] wv;
            int         k;
            wv = wq[i];
            k  = e - sq[i];
            if (aq[i] <= e && e < sq[i]) hf = 1'b1;
            if (k >= 0 && k < W) begin
                bv = 1'b1;
                bm = wv[W-1-k];
                bl = wv[k];
                wd = (k == W - 1);
            end
        end
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        logic hf, bv, bm, bl, wd;
        model(n, hf, bv, bm, bl, wd);
        chk1("m_ready",     if_m.word_ready,   !hf);
        chk1("m_bit_valid", if_m.bit_valid,    bv);
        chk1("m_seq_out",   if_m.sequence_out, bm);
        chk1("m_word_done", if_m.word_done,    wd);
        chk1("m_busy",      if_m.busy,         hf || bv);
        chk1("l_ready",     if_l.word_ready,   !hf);
        chk1("l_bit_valid", if_l.bit_valid,    bv);
        chk1("l_seq_out",   if_l.sequence_out, bl);
        chk1("l_word_done", if_l.word_done,    wd);
        chk1("l_busy",      if_l.busy,         hf || bv);
        if (if_m.bit_valid) cap_m = {cap_m[6:0], if_m.sequence_out};
        if (if_l.bit_valid) cap_l = {cap_l[6:0], if_l.sequence_out};
    endtask

    // One clock: drive at negedge, step the model, check at the next negedge.
    task automatic cycle(input logic v, input logic [7:0] w, output logic acc);
        logic hf, bv, bm, bl, wd;
        int   s;
        if_m.word_valid = v; if_m.word_in = w;
        if_l.word_valid = v; if_l.word_in = w;
        model(n, hf, bv, bm, bl, wd);
        acc = v && !hf;
        @(posedge clk);
        n++;
        if (acc) begin
            s = (n + 1 > last_s + W) ? n + 1 : last_s + W;
            wq.push_back(w);
            aq.push_back(n);
            sq.push_back(s);
            last_s = s;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send_word(input logic [7:0] w);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 4 * W && !acc; i++) cycle(1'b1, w, acc);
        chk1("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 8'h00, acc);
    endtask

    task automatic clear_model();
        wq.delete(); aq.delete(); sq.delete();
        last_s = -100;
    endtask

    initial begin
        logic acc;
        int   s_ff;
        compared = 0; mismatched = 0; n = 0; cap_m = '0; cap_l = '0;
        clear_model();
        rst = 1'b0;
        if_m.word_valid = 1'b0; if_m.word_in = '0;
        if_l.word_valid = 1'b0; if_l.word_in = '0;

        // Reset values.
        #3 rst = 1'b1;
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        idle(2);

        // Single word, MSB first: 8'hB0 streams 1,0,1,1,0,0,0,0.
        send_word(8'hB0);
        idle(12);
        chk8("msb_stream_b0", cap_m, 8'hB0);

        // LSB first: 8'h0D streams 1,0,1,1,0,0,0,0.
        send_word(8'h0D);
        idle(12);
        chk8("lsb_stream_0d", cap_l, 8'hB0);

        // Back-to-back with valid held, then a pulse while the hold is full.
        send_word(8'hB0);
        send_word(8'h2C);
        cycle(1'b1, 8'hEE, acc);
        idle(20);
        chk8("msb_stream_2c", cap_m, 8'h2C);

        // Reset at the 4th bit of 8'hFF with a second word held.
        send_word(8'hFF);
        s_ff = last_s;
        send_word(8'hA5);
        for (int i = 0; i < 4 * W && n < s_ff + 3; i++) cycle(1'b0, 8'h00, acc);
        chk1("fourth_bit_valid", if_m.bit_valid, 1'b1);
        if_m.word_valid = 1'b0; if_l.word_valid = 1'b0;
        rst = 1'b1;
        clear_model();
        #1 check_all();
        @(posedge clk); n++;
        @(negedge clk); check_all();
        rst = 1'b0;
        idle(3);
        send_word(8'h5A);
        idle(12);
        chk8("post_reset_5a", cap_m, 8'h5A);

        // Randomized traffic with varying valid density.
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = $urandom_range(0, 4);
            for (int i = 0; i < 80; i++)
                cycle(($urandom_range(0, 4) < dens), 8'($urandom), acc);
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
